// File: rtl/avalon_packet_arbiter_pkg.sv
// Shared types and helpers for the packet-granular Avalon-ST arbiter.
// The round-robin pick lives here so the core and any future users agree on it.
package avalon_packet_arbiter_pkg;

   localparam int ARB_MAX_N_IN = 8;
   localparam int ARB_PTR_W    = 3;

   typedef enum logic [1:0] {ARB_IDLE, ARB_LOCKED, ARB_DRAIN} arbiter_sm_t;

   // First requester found scanning upward from ptr, wrapping at nIn.
   function automatic int rr_pick(input logic [ARB_MAX_N_IN-1:0] req,
                                  input logic [ARB_PTR_W-1:0]    ptr,
                                  input int                      nIn);
      int   win;
      int   idx;
      logic found;
      win   = int'(ptr);
      found = 1'b0;
      for (int k = 0; k < ARB_MAX_N_IN; k++) begin
         idx = (int'(ptr) + k) % nIn;
         if ((k < nIn) && !found && req[idx[ARB_PTR_W-1:0]]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/avalon_packet_arbiter_if.sv
// Avalon-ST stream bundle; the master drives the beat, the slave drives rdy.
interface avalon_st_if #(
   parameter int DATA_W  = 8,
   parameter int EMPTY_W = 2
);
   logic               valid;
   logic               rdy;
   logic               sop;
   logic               eop;
   logic [DATA_W-1:0]  data;
   logic [EMPTY_W-1:0] empty;

   modport master (output valid, sop, eop, data, empty, input rdy);
   modport slave  (input valid, sop, eop, data, empty, output rdy);
endinterface

// File: rtl/avalon_packet_arbiter_rr_arbiter_core.sv
// Purely combinational round-robin selector: winner index plus a flag saying
// that at least one request was present.
module rr_arbiter_core
   import avalon_packet_arbiter_pkg::*;
#(
   parameter  int N_IN  = 2,
   localparam int PTR_W = $clog2(N_IN)
) (
   input  logic [N_IN-1:0]  i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [PTR_W-1:0] o_winner,
   output logic             o_valid
);

   logic [ARB_MAX_N_IN-1:0] w_reqPad;

   assign w_reqPad = ARB_MAX_N_IN'(i_req);
   assign o_winner = PTR_W'(rr_pick(w_reqPad, ARB_PTR_W'(i_ptr), N_IN));
   assign o_valid  = |i_req;

endmodule

// File: rtl/avalon_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one Avalon-ST output between
// N_IN inputs, with a beat watchdog that truncates runaway packets.
module avalon_packet_arbiter
   import avalon_packet_arbiter_pkg::*;
#(
   parameter  int N_IN      = 2,
   parameter  int MAX_BEATS = 256,
   parameter  int DATA_W    = 8,
   parameter  int EMPTY_W   = 2,
   localparam int GRANT_W   = $clog2(N_IN)
) (
   input  logic               clk,
   input  logic               rst,
   avalon_st_if.slave         in_msg [N_IN],
   avalon_st_if.master        out_msg,
   output logic [GRANT_W-1:0] grant_id,
   output logic               busy,
   output logic               truncated
);

   localparam int CNT_W = $clog2(MAX_BEATS) + 1;

   arbiter_sm_t        r_state;
   arbiter_sm_t        w_nextState;
   logic [GRANT_W-1:0] r_grantId;
   logic [GRANT_W-1:0] r_rrPtr;
   logic [GRANT_W-1:0] w_nextPtr;
   logic [GRANT_W-1:0] w_winner;
   logic [CNT_W-1:0]   r_beatCnt;
   logic               r_truncated;
   logic               w_anyReq;

   logic [N_IN-1:0]    w_valid;
   logic [N_IN-1:0]    w_sop;
   logic [N_IN-1:0]    w_eop;
   logic [N_IN-1:0]    w_rdy;
   logic [DATA_W-1:0]  w_data  [N_IN];
   logic [EMPTY_W-1:0] w_empty [N_IN];

   logic               w_gValid;
   logic               w_gSop;
   logic               w_gEop;
   logic [DATA_W-1:0]  w_gData;
   logic [EMPTY_W-1:0] w_gEmpty;
   logic               w_atLimit;
   logic               w_forceEop;
   logic               w_accept;
   logic               w_truncEvent;
   logic               w_packetDone;

   // Interface arrays cannot be indexed at run time, so flatten them here.
   for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
      assign w_valid[gi]   = in_msg[gi].valid;
      assign w_sop[gi]     = in_msg[gi].sop;
      assign w_eop[gi]     = in_msg[gi].eop;
      assign w_data[gi]    = in_msg[gi].data;
      assign w_empty[gi]   = in_msg[gi].empty;
      assign in_msg[gi].rdy = w_rdy[gi];
   end

   rr_arbiter_core #(.N_IN(N_IN)) u_core (
      .i_req   (w_valid),
      .i_ptr   (r_rrPtr),
      .o_winner(w_winner),
      .o_valid (w_anyReq)
   );

   assign w_gValid  = w_valid[r_grantId];
   assign w_gSop    = w_sop[r_grantId];
   assign w_gEop    = w_eop[r_grantId];
   assign w_gData   = w_data[r_grantId];
   assign w_gEmpty  = w_empty[r_grantId];

   assign w_atLimit    = (r_beatCnt == CNT_W'(MAX_BEATS - 1));
   assign w_forceEop   = (r_state == ARB_LOCKED) && w_atLimit && !w_gEop;
   assign w_accept     = (r_state == ARB_LOCKED) && w_gValid && out_msg.rdy;
   assign w_truncEvent = w_accept && w_forceEop;
   assign w_packetDone = (w_accept && w_gEop) ||
                         ((r_state == ARB_DRAIN) && w_gValid && w_gEop);
   assign w_nextPtr    = (r_grantId == GRANT_W'(N_IN - 1)) ? '0 : r_grantId + GRANT_W'(1);

   assign grant_id  = r_grantId;
   assign busy      = (r_state != ARB_IDLE);
   assign truncated = r_truncated;

   // Output mux and next state: passthrough while locked, swallow beats while draining.
   always_comb begin
      w_nextState   = r_state;
      w_rdy         = '0;
      out_msg.valid = 1'b0;
      out_msg.sop   = 1'b0;
      out_msg.eop   = 1'b0;
      out_msg.data  = '0;
      out_msg.empty = '0;
      case (r_state)
         ARB_IDLE: begin
            if (w_anyReq) w_nextState = ARB_LOCKED;
         end
         ARB_LOCKED: begin
            out_msg.valid    = w_gValid;
            out_msg.sop      = w_gSop;
            out_msg.eop      = w_gEop | w_atLimit;
            out_msg.data     = w_gData;
            out_msg.empty    = w_forceEop ? '0 : w_gEmpty;
            w_rdy[r_grantId] = out_msg.rdy;
            if (w_accept) begin
               if (w_gEop)         w_nextState = ARB_IDLE;
               else if (w_atLimit) w_nextState = ARB_DRAIN;
            end
         end
         ARB_DRAIN: begin
            w_rdy[r_grantId] = 1'b1;
            if (w_gValid && w_gEop) w_nextState = ARB_IDLE;
         end
         default: w_nextState = ARB_IDLE;
      endcase
   end

   // State, grant, round-robin pointer and the saturating beat watchdog.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ARB_IDLE;
         r_grantId   <= '0;
         r_rrPtr     <= '0;
         r_beatCnt   <= '0;
         r_truncated <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_truncated <= w_truncEvent;
         if ((r_state == ARB_IDLE) && w_anyReq) begin
            r_grantId <= w_winner;
            r_beatCnt <= '0;
         end else if (w_accept && (r_beatCnt != '1)) begin
            r_beatCnt <= r_beatCnt + CNT_W'(1);
         end
         if (w_packetDone) r_rrPtr <= w_nextPtr;
      end
   end

endmodule

// File: tb/tb_avalon_packet_arbiter.sv
// Self-checking bench for avalon_packet_arbiter: table-driven packets plus
// hand-written round-robin, watchdog-contention and reset sequences.
module tb_avalon_packet_arbiter;

   localparam int N  = 2;
   localparam int MB = 4;

   typedef struct packed {
      logic       sop;
      logic       eop;
      logic [7:0] data;
      logic [1:0] empty;
   } beat_t;

   typedef struct {
      beat_t b;
      int    grant;
      int    gap;
   } exp_t;

   typedef struct {
      int         port;
      int         nIn;
      logic [7:0] base;
      logic [1:0] emp;
      bit         toggle;
      int         expBeats;
      int         expTrunc;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic grantId;
   logic busy;
   logic truncated;

   avalon_st_if #(.DATA_W(8), .EMPTY_W(2)) inIf [N] ();
   avalon_st_if #(.DATA_W(8), .EMPTY_W(2)) outIf ();

   avalon_packet_arbiter #(.N_IN(N), .MAX_BEATS(MB), .DATA_W(8), .EMPTY_W(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_msg   (inIf),
      .out_msg  (outIf),
      .grant_id (grantId),
      .busy     (busy),
      .truncated(truncated)
   );

   always #5 clk = ~clk;

   beat_t q0 [$];
   beat_t q1 [$];
   exp_t  sbQ [$];
   int    checks = 0;
   int    errors = 0;
   int    cycle = 0;
   int    lastEop = 0;
   int    acceptCount = 0;
   int    truncCount = 0;
   bit    monEnable = 1'b1;
   bit    rdyToggle = 1'b0;
   bit    acc0;
   bit    acc1;
   vec_t  vecs [6];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Requester sources: hold the head beat until it is accepted.
   always @(posedge clk) begin
      acc0 = inIf[0].valid && inIf[0].rdy;
      acc1 = inIf[1].valid && inIf[1].rdy;
      #1;
      if (acc0 && q0.size() != 0) void'(q0.pop_front());
      if (acc1 && q1.size() != 0) void'(q1.pop_front());
      inIf[0].valid = (q0.size() != 0);
      inIf[1].valid = (q1.size() != 0);
      if (q0.size() != 0) {inIf[0].sop, inIf[0].eop, inIf[0].data, inIf[0].empty} = q0[0];
      else                {inIf[0].sop, inIf[0].eop, inIf[0].data, inIf[0].empty} = '0;
      if (q1.size() != 0) {inIf[1].sop, inIf[1].eop, inIf[1].data, inIf[1].empty} = q1[0];
      else                {inIf[1].sop, inIf[1].eop, inIf[1].data, inIf[1].empty} = '0;
      outIf.rdy = rdyToggle ? !outIf.rdy : 1'b1;
   end

   // Output monitor and scoreboard consumer, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         cycle++;
         if (outIf.valid && outIf.rdy) begin
            acceptCount++;
            if (monEnable) begin
               if (sbQ.size() == 0) begin
                  checkOutput("stray_beat", 32'({outIf.sop, outIf.eop, outIf.data, outIf.empty}), 32'hFFFF_FFFF);
               end else begin
                  e = sbQ.pop_front();
                  checkOutput("out_beat", 32'({outIf.sop, outIf.eop, outIf.data, outIf.empty}), 32'(e.b));
                  checkOutput("beat_grant", 32'(grantId), 32'(e.grant));
                  if (e.gap != 0) checkOutput("bubble_gap", 32'(cycle - lastEop), 32'(e.gap));
               end
            end
            if (outIf.eop) lastEop = cycle;
         end
         if (!busy) begin
            checkOutput("idle_rdy", 32'({inIf[1].rdy, inIf[0].rdy}), 32'd0);
         end else begin
            checkOutput("other_rdy", 32'(grantId ? inIf[0].rdy : inIf[1].rdy), 32'd0);
            if (outIf.valid)
               checkOutput("rdy_mirror", 32'(grantId ? inIf[1].rdy : inIf[0].rdy), 32'(outIf.rdy));
         end
         if (truncated) truncCount++;
      end
   end

   task automatic loadPacket(input int port, input int nIn, input logic [7:0] base, input logic [1:0] emp);
      beat_t b;
      for (int k = 0; k < nIn; k++) begin
         b.sop   = (k == 0);
         b.eop   = (k == nIn - 1);
         b.data  = base + 8'(k);
         b.empty = emp;
         if (port == 0) q0.push_back(b);
         else           q1.push_back(b);
      end
   endtask

   task automatic expectPacket(input int port, input int nOut, input logic [7:0] base,
                               input logic [1:0] emp, input bit trunc, input int gap);
      exp_t e;
      for (int k = 0; k < nOut; k++) begin
         e.b.sop   = (k == 0);
         e.b.eop   = (k == nOut - 1);
         e.b.data  = base + 8'(k);
         e.b.empty = (trunc && (k == nOut - 1)) ? 2'd0 : emp;
         e.grant   = port;
         e.gap     = (k == 0) ? gap : 0;
         sbQ.push_back(e);
      end
   endtask

   task automatic waitDone(input string name);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      while (!done && n < 400) begin
         @(posedge clk); #3;
         n++;
         done = (sbQ.size() == 0) && (q0.size() == 0) && (q1.size() == 0) && !busy;
      end
      checkOutput({name, "_complete"}, 32'(done), 32'd1);
      repeat (2) begin @(posedge clk); #3; end
   endtask

   task automatic applyStimulus(input vec_t v);
      int tb0;
      tb0 = truncCount;
      rdyToggle = v.toggle;
      expectPacket(v.port, v.expBeats, v.base, v.emp, v.expTrunc != 0, 0);
      loadPacket(v.port, v.nIn, v.base, v.emp);
      waitDone("table_pkt");
      rdyToggle = 1'b0;
      checkOutput("trunc_pulses", 32'(truncCount - tb0), 32'(v.expTrunc));
      checkOutput("final_grant", 32'(grantId), 32'(v.port));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      int base;
      int n;
      int tb0;
      inIf[0].valid = 1'b0;
      inIf[1].valid = 1'b0;
      outIf.rdy     = 1'b1;

      vecs[0] = '{1, 1, 8'hA5, 2'd0, 1'b0, 1, 0};
      vecs[1] = '{0, 4, 8'h10, 2'd1, 1'b1, 4, 0};
      vecs[2] = '{0, 6, 8'h20, 2'd2, 1'b0, 4, 1};
      vecs[3] = '{1, 4, 8'h30, 2'd3, 1'b0, 4, 0};
      vecs[4] = '{1, 5, 8'h40, 2'd1, 1'b1, 4, 1};
      vecs[5] = '{0, 2, 8'h50, 2'd2, 1'b0, 2, 0};

      repeat (3) @(posedge clk);
      #3;
      checkOutput("rst_out", 32'({outIf.valid, outIf.sop, outIf.eop, outIf.data, outIf.empty}), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_grant", 32'(grantId), 32'd0);
      checkOutput("rst_trunc", 32'(truncated), 32'd0);
      checkOutput("rst_in_rdy", 32'({inIf[1].rdy, inIf[0].rdy}), 32'd0);
      rst = 1'b0;

      // Both inputs stream 3-beat packets; expect strict alternation, one bubble each.
      expectPacket(0, 3, 8'h00, 2'd0, 1'b0, 0);
      expectPacket(1, 3, 8'h80, 2'd1, 1'b0, 2);
      expectPacket(0, 3, 8'h03, 2'd0, 1'b0, 2);
      expectPacket(1, 3, 8'h83, 2'd1, 1'b0, 2);
      loadPacket(0, 3, 8'h00, 2'd0);
      loadPacket(0, 3, 8'h03, 2'd0);
      loadPacket(1, 3, 8'h80, 2'd1);
      loadPacket(1, 3, 8'h83, 2'd1);
      waitDone("round_robin");

      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      // in0 runs away while in1 waits; in1 must get the output after the drain.
      tb0 = truncCount;
      expectPacket(0, 4, 8'hB0, 2'd1, 1'b1, 0);
      expectPacket(1, 2, 8'hC0, 2'd3, 1'b0, 4);
      loadPacket(0, 6, 8'hB0, 2'd1);
      repeat (2) begin @(posedge clk); #3; end
      loadPacket(1, 2, 8'hC0, 2'd3);
      waitDone("watchdog_contend");
      checkOutput("contend_trunc", 32'(truncCount - tb0), 32'd1);

      // Leave rr_ptr at 1, then reset in the middle of an in1 packet.
      expectPacket(0, 1, 8'h60, 2'd0, 1'b0, 0);
      loadPacket(0, 1, 8'h60, 2'd0);
      waitDone("pre_reset");
      monEnable = 1'b0;
      base = acceptCount;
      loadPacket(1, 5, 8'h70, 2'd0);
      n = 0;
      while (acceptCount < base + 2 && n < 100) begin @(posedge clk); #3; n++; end
      checkOutput("mid_pkt_reached", 32'(acceptCount >= base + 2), 32'd1);
      rst = 1'b1;
      q0.delete();
      q1.delete();
      @(posedge clk); #3;
      checkOutput("mid_rst_valid", 32'(outIf.valid), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_grant", 32'(grantId), 32'd0);
      checkOutput("mid_rst_in_rdy", 32'({inIf[1].rdy, inIf[0].rdy}), 32'd0);
      rst = 1'b0;
      sbQ.delete();
      monEnable = 1'b1;
      expectPacket(0, 2, 8'hA0, 2'd2, 1'b0, 0);
      expectPacket(1, 2, 8'h90, 2'd1, 1'b0, 2);
      loadPacket(1, 2, 8'h90, 2'd1);
      loadPacket(0, 2, 8'hA0, 2'd2);
      waitDone("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
